// File: rtl/cache_pkg.sv
// Shared types and default geometry for the N-way cache controller.
package cache_pkg;
  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WB,
    ST_FILL
  } state_t;
endpackage

// File: rtl/nway_victim_select.sv
// Replacement choice: lowest invalid way, otherwise the oldest way (age WAYS-1).
module nway_victim_select #(
  parameter int WAYS = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]            valid_vec,
  input  logic [WAYS-1:0][WAY_W-1:0] ages,
  output logic [WAY_W-1:0]           victim
);
  always_comb begin
    victim = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (ages[i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
    // Invalid ways override the LRU pick; descending loop leaves the lowest index.
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_vec[i]) victim = WAY_W'(i);
  end
endmodule

// File: rtl/nway_cache_ctrl.sv
// N-way set-associative cache controller: hit/miss sequencing, writeback/fill handshake and per-set LRU ages.
module nway_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [IDX_W-1:0] req_index,
  output logic             req_ready,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  output logic             resp_valid,
  output logic [WAY_W-1:0] way_sel,
  output logic             data_we,
  output logic             tag_we,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             mem_req_valid,
  output logic             mem_req_write,
  input  logic             mem_ack,
  output logic             multi_hit_err
);
  state_t state, state_d;

  logic                              write_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [WAY_W-1:0]                  victim_q;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age;

  logic [WAYS-1:0]  qual;
  logic             any_hit, multi;
  logic [WAY_W-1:0] hit_way, victim;

  assign qual    = hit_vec & valid_vec;
  assign any_hit = |qual;
  assign multi   = |(qual & (qual - WAYS'(1)));

  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (qual[i]) hit_way = WAY_W'(i);
  end

  nway_victim_select #(.WAYS(WAYS)) u_victim (
    .valid_vec (valid_vec),
    .ages      (age[idx_q]),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      write_q       <= 1'b0;
      idx_q         <= '0;
      victim_q      <= '0;
      multi_hit_err <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else begin
      state <= state_d;
      if (state == ST_IDLE && req_valid) begin
        write_q <= req_write;
        idx_q   <= req_index;
      end
      if (state == ST_COMPARE && !any_hit) victim_q <= victim;
      if (state == ST_COMPARE && multi) multi_hit_err <= 1'b1;
      // Ages only move on a hit; a miss is accounted for by the re-lookup hit after fill.
      if (state == ST_COMPARE && any_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way)
            age[idx_q][w] <= '0;
          else if (age[idx_q][w] < age[idx_q][hit_way])
            age[idx_q][w] <= age[idx_q][w] + WAY_W'(1);
        end
      end
    end
  end

  assign req_ready = (state == ST_IDLE);

  always_comb begin
    state_d       = state;
    resp_valid    = 1'b0;
    way_sel       = '0;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (any_hit) begin
          way_sel    = hit_way;
          resp_valid = 1'b1;
          data_we    = write_q;
          set_dirty  = write_q;
          state_d    = ST_IDLE;
        end else begin
          state_d = (valid_vec[victim] && dirty_vec[victim]) ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        way_sel       = victim_q;
        if (mem_ack) begin
          clr_dirty = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_req_valid = 1'b1;
        way_sel       = victim_q;
        if (mem_ack) begin
          data_we   = 1'b1;
          tag_we    = 1'b1;
          set_valid = 1'b1;
          state_d   = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_nway_cache_ctrl.sv
// Randomized bench: acts as the tag/valid/dirty arrays and predicts controller behaviour from a recency-queue cache model.
module tb_nway_cache_ctrl;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int IDX_W = 4;
  localparam int WAY_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [IDX_W-1:0] req_index = '0;
  logic req_ready;
  logic [WAYS-1:0] hit_vec, valid_vec, dirty_vec;
  logic resp_valid;
  logic [WAY_W-1:0] way_sel;
  logic data_we, tag_we, set_valid, set_dirty, clr_dirty;
  logic mem_req_valid, mem_req_write;
  logic mem_ack = 1'b0;
  logic multi_hit_err;

  always #5 clk = ~clk;

  nway_cache_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_index(req_index), .req_ready(req_ready),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .resp_valid(resp_valid), .way_sel(way_sel),
    .data_we(data_we), .tag_we(tag_we), .set_valid(set_valid), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_ack(mem_ack),
    .multi_hit_err(multi_hit_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Cache contents model; rec[s] holds ways in recency order, MRU first.
  logic [WAYS-1:0] m_valid[SETS];
  logic [WAYS-1:0] m_dirty[SETS];
  int m_tag[SETS][WAYS];
  int rec[SETS][$];
  int cur_idx = 0;
  int cur_tag = 0;
  logic [WAYS-1:0] hit_extra = '0;
  bit exp_multi = 1'b0;
  int last_way;
  bit last_wb, last_miss;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = (m_tag[cur_idx][w] == cur_tag) | hit_extra[w];
  end
  assign valid_vec = m_valid[cur_idx];
  assign dirty_vec = m_dirty[cur_idx];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      rec[s].delete();
      for (int w = 0; w < WAYS; w++) rec[s].push_back(w);
    end
    exp_multi = 1'b0;
  endtask

  task automatic touch(input int s, input int k);
    for (int i = 0; i < rec[s].size(); i++)
      if (rec[s][i] == k) begin
        rec[s].delete(i);
        break;
      end
    rec[s].push_front(k);
  endtask

  function automatic int pick_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
    return rec[s][WAYS-1];
  endfunction

  task automatic fill_set(input int s, input int base);
    m_valid[s] = '1;
    m_dirty[s] = '0;
    for (int w = 0; w < WAYS; w++) m_tag[s][w] = base + w;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic serve(input bit wb, input int v, input int dly);
    for (int i = 0; i <= dly; i++) begin
      #1;
      chk(wb ? "wb_req" : "fill_req", mem_req_valid, 1);
      chk("mem_req_write", mem_req_write, 32'(wb));
      chk("mem_way", way_sel, v);
      chk("mem_resp", resp_valid, 0);
      if (i == dly) begin
        mem_ack = 1'b1;
        #1;
        if (wb) begin
          chk("wb_clr_dirty", clr_dirty, 1);
          chk("wb_data_we", data_we, 0);
        end else begin
          chk("fill_data_we", data_we, 1);
          chk("fill_tag_we", tag_we, 1);
          chk("fill_set_valid", set_valid, 1);
          chk("fill_clr_dirty", clr_dirty, 0);
        end
      end else begin
        chk("wait_clr_dirty", clr_dirty, 0);
        chk("wait_data_we", data_we, 0);
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
  endtask

  // One CPU access from IDLE to its response, including any writeback/fill.
  task automatic access(input bit wr, input int idx, input int tag, input int dly);
    logic [WAYS-1:0] q;
    int hw, nh, v, guard;
    bit done;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready", req_ready, 1);
    cur_idx = idx;
    cur_tag = tag;
    req_valid = 1'b1;
    req_write = wr;
    req_index = IDX_W'(idx);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_index = IDX_W'($urandom);
    mem_ack   = 1'($urandom);
    last_miss = 1'b0;
    last_wb   = 1'b0;
    done      = 1'b0;
    for (int pass = 0; pass < 2 && !done; pass++) begin
      #1;
      q = hit_vec & valid_vec;
      if (q != '0) begin
        hw = -1;
        nh = 0;
        for (int w = WAYS - 1; w >= 0; w--)
          if (q[w]) begin
            hw = w;
            nh++;
          end
        if (nh > 1) exp_multi = 1'b1;
        chk("hit_resp", resp_valid, 1);
        chk("hit_way", way_sel, hw);
        chk("hit_data_we", data_we, 32'(wr));
        chk("hit_set_dirty", set_dirty, 32'(wr));
        chk("hit_tag_we", tag_we, 0);
        chk("hit_mem_req", mem_req_valid, 0);
        mem_ack = 1'b0;
        @(negedge clk);
        if (wr) m_dirty[idx][hw] = 1'b1;
        touch(idx, hw);
        #1;
        chk("multi_hit_err", multi_hit_err, 32'(exp_multi));
        chk("resp_pulse", resp_valid, 0);
        last_way = hw;
        done = 1'b1;
      end else begin
        v = pick_victim(idx);
        chk("miss_resp", resp_valid, 0);
        chk("miss_mem_req", mem_req_valid, 0);
        chk("miss_data_we", data_we, 0);
        mem_ack = 1'b0;
        @(negedge clk);
        last_miss = 1'b1;
        last_way  = v;
        if (m_valid[idx][v] && m_dirty[idx][v]) begin
          serve(1'b1, v, dly);
          m_dirty[idx][v] = 1'b0;
          last_wb = 1'b1;
        end
        serve(1'b0, v, dly);
        m_valid[idx][v] = 1'b1;
        m_dirty[idx][v] = 1'b0;
        m_tag[idx][v]   = tag;
      end
    end
    if (!done) chk("refill_hit", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = '0;
      m_dirty[s] = '0;
      for (int w = 0; w < WAYS; w++) m_tag[s][w] = -1;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp", resp_valid, 0);
    chk("rst_way_sel", way_sel, 0);
    chk("rst_strobes", {data_we, tag_we, set_valid, set_dirty, clr_dirty}, 0);
    chk("rst_mem", {mem_req_valid, mem_req_write}, 0);
    chk("rst_multi", multi_hit_err, 0);
    rst_n = 1'b1;
    model_reset();

    fill_set(3, 100);
    access(1'b0, 3, 102, 0);
    chk("ld_hit_way", last_way, 2);
    chk("ld_hit_nomiss", last_miss, 0);

    fill_set(5, 200);
    access(1'b0, 5, 999, 1);
    chk("fill_victim", last_way, 3);
    chk("fill_no_wb", last_wb, 0);

    do_reset();
    fill_set(7, 300);
    m_dirty[7] = 4'b1000;
    access(1'b1, 7, 998, 3);
    chk("wb_victim", last_way, 3);
    chk("wb_taken", last_wb, 1);

    do_reset();
    fill_set(0, 400);
    for (int k = 0; k < WAYS; k++) access(1'b0, 0, 400 + k, 0);
    access(1'b0, 0, 997, 0);
    chk("lru_victim", last_way, 0);

    fill_set(1, 500);
    hit_extra = 4'b0100;
    access(1'b0, 1, 501, 0);
    chk("multi_way", last_way, 1);
    chk("multi_err", multi_hit_err, 1);
    hit_extra = '0;
    access(1'b1, 1, 502, 2);
    chk("multi_sticky", multi_hit_err, 1);
    do_reset();
    #1;
    chk("multi_clr", multi_hit_err, 0);

    // Reset while a fill is outstanding.
    fill_set(9, 600);
    cur_idx = 9;
    cur_tag = 996;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_index = IDX_W'(9);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rstfill_req", mem_req_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rstfill_mem", mem_req_valid, 0);
    chk("rstfill_resp", resp_valid, 0);
    chk("rstfill_idle", req_ready, 1);
    rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 200; n++)
      access(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
